grf_write_queue: RTL

// - Producer side of the GRF write port: collects register writebacks from the pipeline W stage and the multiply/divide unit.
// - Orders them in a small FIFO and drives the GRF write port (Wr/A3/WD) at most one write per cycle.
// - Lookup ports report pending writes so the D-stage hazard unit can stall or forward.

---
 rtl/grf_write_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/grf_write_queue.sv
// Write-back queue in front of the GRF write port: merges W-stage and MDU writes and exposes pending writes for hazard lookup.
// Optional: define GRF_WRITE_QUEUE_TRACE_EN to print each issued GRF write in the simulator trace format.
module grf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PCW   = 32,
  localparam int IW   = $clog2(DEPTH),
  localparam int CW   = IW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           p_valid,
  output logic           p_ready,
  input  logic [AW-1:0]  p_addr,
  input  logic [DW-1:0]  p_data,
  input  logic [PCW-1:0] p_pc,
  input  logic           m_valid,
  output logic           m_ready,
  input  logic [AW-1:0]  m_addr,
  input  logic [DW-1:0]  m_data,
  input  logic [PCW-1:0] m_pc,
  input  logic           grf_hold,
  output logic           grf_we,
  output logic [AW-1:0]  grf_a3,
  output logic [DW-1:0]  grf_wd,
  output logic [PCW-1:0] grf_pc,
  input  logic [AW-1:0]  q_addr1,
  input  logic [AW-1:0]  q_addr2,
  output logic           q_hit1,
  output logic           q_hit2,
  output logic [DW-1:0]  q_data1,
  output logic [DW-1:0]  q_data2,
  output logic [CW-1:0]  count
);

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [PCW-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [CW-1:0] rd_ptr, wr_ptr;
  logic          full, empty, pop, push_p, push_m, enq;
  entry_t        head, in_entry;

  // Occupancy falls out of the wrap-bit pointers; no separate valid bits needed.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[IW-1:0]];

  assign pop     = !rst && !empty && !grf_hold;
  assign p_ready = !rst && (!full || pop);
  assign m_ready = !rst && !p_valid && (!full || pop);
  assign push_p  = p_valid && p_ready;
  assign push_m  = m_valid && m_ready;

  always_comb begin
    in_entry = '{addr: m_addr, data: m_data, pc: m_pc};
    if (push_p) in_entry = '{addr: p_addr, data: p_data, pc: p_pc};
  end

  // Writes to $0 complete the handshake but never occupy a slot.
  assign enq = (push_p || push_m) && (in_entry.addr != '0);

  assign grf_we = pop;
  assign grf_a3 = (!rst && !empty) ? head.addr : '0;
  assign grf_wd = (!rst && !empty) ? head.data : '0;
  assign grf_pc = (!rst && !empty) ? head.pc   : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && enq) mem[wr_ptr[IW-1:0]] <= in_entry;
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    logic [IW-1:0] idx;
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr[IW-1:0] + IW'(i);
      if (!rst && (CW'(i) < count)) begin
        if (q_addr1 != '0 && mem[idx].addr == q_addr1) begin
          q_hit1  = 1'b1;
          q_data1 = mem[idx].data;
        end
        if (q_addr2 != '0 && mem[idx].addr == q_addr2) begin
          q_hit2  = 1'b1;
          q_data2 = mem[idx].data;
        end
      end
    end
  end

`ifdef GRF_WRITE_QUEUE_TRACE_EN
  always @(posedge clk) begin
    if (grf_we) $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
  end
`endif

endmodule
